bcd_time_counter: RTL and testbench

//  Time-of-day counter: writer of the packed 24-bit BCD HH:MM:SS word that the display digit mux reads.

---
 rtl/clock_pkg.sv | 22 ++
 rtl/bcd_pair_counter.sv | 49 ++++
 rtl/bcd_time_counter.sv | 122 ++++++++++++
 tb/tb_bcd_time_counter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the time-of-day counter: digit-pair positions in the
// packed HH:MM:SS word, per-pair BCD limits, and the load validity check.
package clock_pkg;

   localparam int SEC_LO = 0;
   localparam int SEC_HI = 4;
   localparam int MIN_LO = 8;
   localparam int MIN_HI = 12;
   localparam int HR_LO  = 16;
   localparam int HR_HI  = 20;

   localparam logic [7:0] SEC_MAX = 8'h59;
   localparam logic [7:0] MIN_MAX = 8'h59;
   localparam logic [7:0] HR_MAX  = 8'h23;

   // Valid ones digit plus an in-range value. BCD bytes order the same way as
   // their decimal meaning, so a plain compare against max also bounds the tens.
   function automatic logic bcd_valid_pair(input logic [7:0] pair, input logic [7:0] max);
      return (pair[3:0] <= 4'd9) && (pair <= max);
   endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter that wraps at MAX. Priority: load > clr > inc.
// carry flags the increment that wraps MAX back to 00.
module bcd_pair_counter
   import clock_pkg::*;
#(
   parameter logic [7:0] MAX = 8'h59
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       inc,
   input  logic       clr,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] value,
   output logic       carry
);

   logic [7:0] value_reg;
   logic [7:0] value_next;

   always_comb begin
      value_next = value_reg;
      if (load) begin
         value_next = load_val;
      end else if (clr) begin
         value_next = 8'h00;
      end else if (inc) begin
         if (value_reg == MAX) begin
            value_next = 8'h00;
         end else if (value_reg[3:0] == 4'd9) begin
            value_next = {value_reg[7:4] + 4'd1, 4'd0};
         end else begin
            value_next = {value_reg[7:4], value_reg[3:0] + 4'd1};
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         value_reg <= 8'h00;
      end else begin
         value_reg <= value_next;
      end
   end

   assign value = value_reg;
   assign carry = inc && (value_reg == MAX);

endmodule

// File: rtl/bcd_time_counter.sv
// Time-of-day counter: 1 Hz prescaler driving a sec/min/hr BCD cascade,
// with a validated load path and per-field increment buttons.
module bcd_time_counter
   import clock_pkg::*;
#(
   parameter int CLK_HZ  = 100_000_000,
   parameter int PRESC_W = 27
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        run,
   input  logic        load,
   input  logic [23:0] load_time,
   input  logic        min_inc,
   input  logic        hr_inc,
   output logic [23:0] count,
   output logic        sec_tick,
   output logic        day_wrap,
   output logic        load_err
);

   localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(CLK_HZ - 1);
   localparam logic [7:0] PAIR_MAX [3] = '{SEC_MAX, MIN_MAX, HR_MAX};

   logic [PRESC_W-1:0] presc_reg;
   logic [PRESC_W-1:0] presc_next;
   logic               sec_tick_reg;
   logic               day_wrap_reg;
   logic               load_err_reg;

   logic               tick_int;
   logic               tick_apply;
   logic               load_ok;
   logic               presc_clr;
   logic [2:0]         pair_inc;
   logic [2:0]         pair_clr;
   logic [2:0]         pair_load;
   logic [2:0]         pair_carry;
   logic [7:0]         sec_val;
   logic [7:0]         min_val;
   logic [7:0]         hr_val;

   assign sec_val = count[SEC_LO +: 8];
   assign min_val = count[MIN_LO +: 8];
   assign hr_val  = count[HR_LO +: 8];

   assign tick_int = run && (presc_reg == PRESC_TC);
   assign load_ok  = bcd_valid_pair(load_time[SEC_LO +: 8], SEC_MAX) &&
                     bcd_valid_pair(load_time[MIN_LO +: 8], MIN_MAX) &&
                     bcd_valid_pair(load_time[HR_LO +: 8],  HR_MAX);

   // One source of change per cycle; a tick that loses arbitration is dropped.
   always_comb begin
      pair_inc   = 3'b000;
      pair_clr   = 3'b000;
      pair_load  = 3'b000;
      presc_clr  = 1'b0;
      tick_apply = 1'b0;
      if (load) begin
         if (load_ok) begin
            pair_load = 3'b111;
            presc_clr = 1'b1;
         end
      end else if (min_inc || hr_inc) begin
         pair_inc[1] = min_inc;
         pair_clr[0] = min_inc;
         pair_inc[2] = hr_inc;
         presc_clr   = 1'b1;
      end else if (tick_int) begin
         tick_apply  = 1'b1;
         pair_inc[0] = 1'b1;
         pair_inc[1] = (sec_val == SEC_MAX);
         pair_inc[2] = (sec_val == SEC_MAX) && (min_val == MIN_MAX);
      end
   end

   always_comb begin
      presc_next = presc_reg;
      if (presc_clr) begin
         presc_next = '0;
      end else if (run) begin
         presc_next = tick_int ? '0 : presc_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_reg    <= '0;
         sec_tick_reg <= 1'b0;
         day_wrap_reg <= 1'b0;
         load_err_reg <= 1'b0;
      end else begin
         presc_reg    <= presc_next;
         sec_tick_reg <= tick_int;
         day_wrap_reg <= tick_apply && (&pair_carry);
         load_err_reg <= load && !load_ok;
      end
   end

   // Pair 0 = seconds, 1 = minutes, 2 = hours.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_pair
         bcd_pair_counter #(
            .MAX(PAIR_MAX[gi])
         ) u_pair (
            .clk      (clk),
            .reset_n  (reset_n),
            .inc      (pair_inc[gi]),
            .clr      (pair_clr[gi]),
            .load     (pair_load[gi]),
            .load_val (load_time[8*gi +: 8]),
            .value    (count[8*gi +: 8]),
            .carry    (pair_carry[gi])
         );
      end
   endgenerate

   assign sec_tick = sec_tick_reg;
   assign day_wrap = day_wrap_reg;
   assign load_err = load_err_reg;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Self-checking bench for bcd_time_counter with a 4-cycle second (CLK_HZ=4).
// Expected outputs are queued as each cycle is driven and compared after the edge.
module tb_bcd_time_counter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        run = 1'b0;
   logic        load = 1'b0;
   logic [23:0] load_time = 24'h0;
   logic        min_inc = 1'b0;
   logic        hr_inc = 1'b0;
   logic [23:0] count;
   logic        sec_tick;
   logic        day_wrap;
   logic        load_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        run;
      logic        load;
      logic [23:0] lt;
      logic        mi;
      logic        hi;
      logic [23:0] exp_count;
      logic        exp_tick;
      logic        chk_tick;
      logic        exp_wrap;
      logic        exp_err;
   } vec_t;

   typedef struct {
      string       name;
      int          idx;
      logic [23:0] count;
      logic        tick;
      logic        chk_tick;
      logic        wrap;
      logic        err;
   } exp_t;

   vec_t tbl[$];
   exp_t exp_q[$];

   bcd_time_counter #(
      .CLK_HZ  (4),
      .PRESC_W (3)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .run       (run),
      .load      (load),
      .load_time (load_time),
      .min_inc   (min_inc),
      .hr_inc    (hr_inc),
      .count     (count),
      .sec_tick  (sec_tick),
      .day_wrap  (day_wrap),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [23:0] to_bcd(input int secs);
      int h, m, s;
      h = secs / 3600;
      m = (secs / 60) % 60;
      s = secs % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic vec_t mk(input logic r, ld, input logic [23:0] lt, input logic mi, hi,
                               input logic [23:0] ec, input logic et, ct, ew, ee);
      vec_t v;
      v.run = r; v.load = ld; v.lt = lt; v.mi = mi; v.hi = hi;
      v.exp_count = ec; v.exp_tick = et; v.chk_tick = ct; v.exp_wrap = ew; v.exp_err = ee;
      return v;
   endfunction

   task automatic cmp24(input string name, input int idx, input logic [23:0] got, input logic [23:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s[%0d] count got %06h want %06h", name, idx, got, want);
      end
   endtask

   task automatic cmp1(input string name, input int idx, input string sig, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s[%0d] %s got %b want %b", name, idx, sig, got, want);
      end
   endtask

   task automatic check_front();
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard empty got count %06h want <entry>", count);
         return;
      end
      e = exp_q.pop_front();
      cmp24(e.name, e.idx, count, e.count);
      if (e.chk_tick) cmp1(e.name, e.idx, "sec_tick", sec_tick, e.tick);
      cmp1(e.name, e.idx, "day_wrap", day_wrap, e.wrap);
      cmp1(e.name, e.idx, "load_err", load_err, e.err);
      $display("%s[%0d] count=%06h tick=%b wrap=%b err=%b", e.name, e.idx, count, sec_tick, day_wrap, load_err);
   endtask

   task automatic drive_step(input logic r, ld, input logic [23:0] lt, input logic mi, hi, input exp_t e);
      @(negedge clk);
      run = r; load = ld; load_time = lt; min_inc = mi; hr_inc = hi;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_front();
   endtask

   initial begin
      exp_t e;

      // Power-up reset held across edges.
      repeat (2) @(posedge clk);
      #1;
      cmp24("reset", 0, count, 24'h000000);
      cmp1("reset", 0, "sec_tick", sec_tick, 1'b0);
      cmp1("reset", 0, "day_wrap", day_wrap, 1'b0);
      cmp1("reset", 0, "load_err", load_err, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;

      // Free run: one second every 4 cycles, 61 seconds.
      for (int k = 1; k <= 4 * 61; k++) begin
         e = '{name: "run", idx: k, count: to_bcd(k / 4), tick: (k % 4 == 0),
               chk_tick: 1'b1, wrap: 1'b0, err: 1'b0};
         drive_step(1'b1, 1'b0, 24'h0, 1'b0, 1'b0, e);
      end
      cmp24("run_end", 0, count, 24'h000101);

      // Async reset mid-operation, right after a tick pulse.
      #2;
      reset_n = 1'b0;
      #1;
      cmp24("areset", 0, count, 24'h000000);
      cmp1("areset", 0, "sec_tick", sec_tick, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      cmp24("areset", 1, count, 24'h000000);
      cmp1("areset", 1, "sec_tick", sec_tick, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      run = 1'b0;
      for (int k = 0; k < 2; k++) begin
         e = '{name: "hold", idx: k, count: 24'h000000, tick: 1'b0, chk_tick: 1'b1, wrap: 1'b0, err: 1'b0};
         drive_step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, e);
      end

      // Day wrap and its neighbour.
      tbl.push_back(mk(1'b0, 1'b1, 24'h235959, 1'b0, 1'b0, 24'h235959, 1'b0, 1'b1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h235959, 1'b0, 1'b1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h235959, 1'b0, 1'b1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h235959, 1'b0, 1'b1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 24'h235958, 1'b0, 1'b0, 24'h235958, 1'b0, 1'b1, 1'b0, 1'b0));
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h235958, 1'b0, 1'b1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h235959, 1'b1, 1'b1, 1'b0, 1'b0));
      // Rejected loads: minutes 60, hours 24, seconds ones digit A.
      tbl.push_back(mk(1'b0, 1'b1, 24'h126000, 1'b0, 1'b0, 24'h235959, 1'b0, 1'b1, 1'b0, 1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h235959, 1'b0, 1'b1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 24'h240000, 1'b0, 1'b0, 24'h235959, 1'b0, 1'b1, 1'b0, 1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h235959, 1'b0, 1'b1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 24'h00005A, 1'b0, 1'b0, 24'h235959, 1'b0, 1'b1, 1'b0, 1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h235959, 1'b0, 1'b1, 1'b0, 1'b0));
      // Set buttons: no cross-field carry.
      tbl.push_back(mk(1'b0, 1'b1, 24'h105942, 1'b0, 1'b0, 24'h105942, 1'b0, 1'b1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 24'h100000, 1'b0, 1'b1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 24'h235942, 1'b0, 1'b0, 24'h235942, 1'b0, 1'b1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 24'h005942, 1'b0, 1'b1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 24'h010000, 1'b0, 1'b1, 1'b0, 1'b0));
      // Freeze mid-prescale, then resume.
      tbl.push_back(mk(1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h010000, 1'b0, 1'b1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h010000, 1'b0, 1'b1, 1'b0, 1'b0));
      for (int k = 0; k < 10; k++)
         tbl.push_back(mk(1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h010000, 1'b0, 1'b1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h010000, 1'b0, 1'b1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h010001, 1'b1, 1'b1, 1'b0, 1'b0));
      // Tick coincident with min_inc: tick dropped, prescaler restarts.
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h010001, 1'b0, 1'b1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 24'h010100, 1'b0, 1'b0, 1'b0, 1'b0));
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h010100, 1'b0, 1'b1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h010101, 1'b1, 1'b1, 1'b0, 1'b0));

      for (int i = 0; i < tbl.size(); i++) begin
         e = '{name: "vec", idx: i, count: tbl[i].exp_count, tick: tbl[i].exp_tick,
               chk_tick: tbl[i].chk_tick, wrap: tbl[i].exp_wrap, err: tbl[i].exp_err};
         drive_step(tbl[i].run, tbl[i].load, tbl[i].lt, tbl[i].mi, tbl[i].hi, e);
      end

      @(negedge clk);
      run = 1'b0; load = 1'b0; min_inc = 1'b0; hr_inc = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
